// File: rtl/axi_slv_rsp_model.sv
// axi_slv_rsp_model: AXI4 slave response model that terminates one slave port.
// AW/AR requests are queued in FIFOs. W beats are checked against the head AW.
// B and R responses come back in order. R data is a checkable address pattern.
// Ready/valid throttling uses per-channel LFSRs, so a trace repeats for a given seed.
`timescale 1ns/1ps

module axi_slv_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_one
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   w_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_cnt   = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_one   = (w_cnt == (PTR_W+1)'(1));
  assign o_dout  = r_mem[r_rptr[PTR_W-1:0]];

  // A pop at full frees the slot that the same-cycle push then reuses.
  // A push at empty becomes visible only on the next cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  // Storage array; it needs no reset because the pointers qualify it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_din;
  end
endmodule

module axi_slv_rsp_model #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       ID_W       = 4,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       OSTD_NUM   = 4,
  parameter int unsigned       READY_MODE = 0,
  parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h1000_0000)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_awvalid,
  output logic              out_awready,
  input  logic [ID_W-1:0]   in_awid,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [7:0]        in_awlen,
  input  logic              in_wvalid,
  output logic              out_wready,
  input  logic              in_wlast,
  output logic              out_bvalid,
  input  logic              in_bready,
  output logic [ID_W-1:0]   out_bid,
  output logic [1:0]        out_bresp,
  input  logic              in_arvalid,
  output logic              out_arready,
  input  logic [ID_W-1:0]   in_arid,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [7:0]        in_arlen,
  output logic              out_rvalid,
  input  logic              in_rready,
  output logic [ID_W-1:0]   out_rid,
  output logic [DATA_W-1:0] out_rdata,
  output logic [1:0]        out_rresp,
  output logic              out_rlast
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned NCH   = 4;
  localparam int unsigned CH_AW = 0;
  localparam int unsigned CH_W  = 1;
  localparam int unsigned CH_AR = 2;
  localparam int unsigned CH_R  = 3;
  localparam int unsigned AW_FW = ID_W + 1 + 8;
  localparam int unsigned AR_FW = ID_W + ADDR_W + 8;
  localparam int unsigned B_FW  = ID_W + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            oor;
    logic [7:0]      len;
  } aw_ent_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } ar_ent_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_ent_t;

  logic [NCH-1:0][15:0] r_lfsr;
  logic [NCH-1:0]       w_thr;
  logic                 r_out_en;

  aw_ent_t     w_aw_din;
  aw_ent_t     w_aw_head;
  logic        w_aw_push;
  logic        w_aw_pop;
  logic        w_aw_empty;
  logic        w_aw_full;
  logic        w_aw_one;

  logic [7:0]  r_wbeat;
  logic        w_wfire;
  logic        w_wlen_hit;
  logic        w_wend;

  b_ent_t      w_b_din;
  b_ent_t      w_b_head;
  logic        w_b_push;
  logic        w_b_pop;
  logic        w_b_empty;
  logic        w_b_full;
  logic        w_b_one;

  ar_ent_t     w_ar_din;
  ar_ent_t     w_ar_head;
  logic        w_ar_push;
  logic        w_ar_pop;
  logic        w_ar_empty;
  logic        w_ar_full;
  logic        w_ar_one;
  logic        w_ar_avail;

  logic        r_rvalid;
  logic [7:0]  r_rbeat;
  logic        w_rfire;
  logic        w_rlast;
  logic [ADDR_W-1:0] w_raddr;

  logic        w_unused;

  assign w_unused = &{1'b0, w_aw_one, w_b_one};

  // Per-channel LFSR x^16+x^14+x^13+x^11+1, stepping every cycle from seed ^ index
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NCH; i++) r_lfsr[i] <= LFSR_SEED ^ 16'(i);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_lfsr[i] <= {r_lfsr[i][0] ^ r_lfsr[i][2] ^ r_lfsr[i][3] ^ r_lfsr[i][5],
                      r_lfsr[i][15:1]};
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_thr
    assign w_thr[g] = (READY_MODE == 0) ? 1'b1 : r_lfsr[g][0];
  end

  // Holds every ready low while reset is asserted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_out_en <= 1'b0;
    else          r_out_en <= 1'b1;
  end

  // AW: queue {id, out-of-range flag, len}
  assign out_awready  = r_out_en & ~w_aw_full & w_thr[CH_AW];
  assign w_aw_push    = in_awvalid & out_awready;
  assign w_aw_din.id  = in_awid;
  assign w_aw_din.oor = (in_awaddr >= ADDR_LIMIT);
  assign w_aw_din.len = in_awlen;

  axi_slv_rsp_fifo #(.WIDTH(AW_FW), .DEPTH(OSTD_NUM)) u_aw_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_aw_push),
    .i_din   (w_aw_din),
    .i_pop   (w_aw_pop),
    .o_dout  (w_aw_head),
    .o_empty (w_aw_empty),
    .o_full  (w_aw_full),
    .o_one   (w_aw_one)
  );

  // W: a burst ends on wlast or on the len-th beat, whichever comes first
  assign out_wready = r_out_en & ~w_aw_empty & ~w_b_full & w_thr[CH_W];
  assign w_wfire    = in_wvalid & out_wready;
  assign w_wlen_hit = (r_wbeat == w_aw_head.len);
  assign w_wend     = w_wfire & (in_wlast | w_wlen_hit);
  assign w_aw_pop   = w_wend;
  assign w_b_push   = w_wend;
  assign w_b_din.id = w_aw_head.id;
  assign w_b_din.resp = (w_aw_head.oor | (in_wlast != w_wlen_hit)) ? RESP_SLVERR : RESP_OKAY;

  // Write beat counter within the head AW burst
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     r_wbeat <= '0;
    else if (w_wend)  r_wbeat <= '0;
    else if (w_wfire) r_wbeat <= r_wbeat + 8'd1;
  end

  axi_slv_rsp_fifo #(.WIDTH(B_FW), .DEPTH(OSTD_NUM)) u_b_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_b_push),
    .i_din   (w_b_din),
    .i_pop   (w_b_pop),
    .o_dout  (w_b_head),
    .o_empty (w_b_empty),
    .o_full  (w_b_full),
    .o_one   (w_b_one)
  );

  // B: present the head entry; payload reads zero while idle
  assign out_bvalid = ~w_b_empty;
  assign w_b_pop    = out_bvalid & in_bready;
  assign out_bid    = out_bvalid ? w_b_head.id   : '0;
  assign out_bresp  = out_bvalid ? w_b_head.resp : RESP_OKAY;

  // AR: queue {id, addr, len}
  assign out_arready   = r_out_en & ~w_ar_full & w_thr[CH_AR];
  assign w_ar_push     = in_arvalid & out_arready;
  assign w_ar_din.id   = in_arid;
  assign w_ar_din.addr = in_araddr;
  assign w_ar_din.len  = in_arlen;

  axi_slv_rsp_fifo #(.WIDTH(AR_FW), .DEPTH(OSTD_NUM)) u_ar_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_ar_push),
    .i_din   (w_ar_din),
    .i_pop   (w_ar_pop),
    .o_dout  (w_ar_head),
    .o_empty (w_ar_empty),
    .o_full  (w_ar_full),
    .o_one   (w_ar_one)
  );

  // R: an entry still queued after this cycle's pop may start or continue a burst.
  // The push of this cycle is excluded, so the first beat trails the AR handshake.
  assign w_rfire    = r_rvalid & in_rready;
  assign w_rlast    = (r_rbeat == w_ar_head.len);
  assign w_ar_pop   = w_rfire & w_rlast;
  assign w_ar_avail = ~w_ar_empty & ~(w_ar_pop & w_ar_one);

  // Registered rvalid: once raised it stays until the beat is taken
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                   r_rvalid <= 1'b0;
    else if (r_rvalid & ~in_rready) r_rvalid <= 1'b1;
    else                            r_rvalid <= w_ar_avail & w_thr[CH_R];
  end

  // Read beat counter within the head AR burst
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)      r_rbeat <= '0;
    else if (w_ar_pop) r_rbeat <= '0;
    else if (w_rfire)  r_rbeat <= r_rbeat + 8'd1;
  end

  // R payload is a function of the head entry and beat count, so it is stable while stalled
  assign w_raddr    = w_ar_head.addr + ADDR_W'(r_rbeat) * ADDR_W'(BYTES);
  assign out_rvalid = r_rvalid;
  assign out_rid    = r_rvalid ? w_ar_head.id : '0;
  assign out_rdata  = r_rvalid ? DATA_W'(w_raddr) : '0;
  assign out_rresp  = (r_rvalid && (w_ar_head.addr >= ADDR_LIMIT)) ? RESP_SLVERR : RESP_OKAY;
  assign out_rlast  = r_rvalid & w_rlast;
endmodule

// File: tb/tb_axi_slv_rsp_model.sv
// Scoreboard bench for axi_slv_rsp_model: an unthrottled instance for directed
// write/read checks and an LFSR-throttled instance for read back-pressure and reset.
`timescale 1ns/1ps

module tb_axi_slv_rsp_model;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // unthrottled instance
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  bresp, rresp;

  // throttled instance
  logic        awvalid_1, awready_1, wvalid_1, wready_1, wlast_1, bvalid_1, bready_1;
  logic        arvalid_1, arready_1, rvalid_1, rready_1, rlast_1;
  logic [3:0]  awid_1, bid_1, arid_1, rid_1;
  logic [31:0] awaddr_1, araddr_1, rdata_1;
  logic [7:0]  awlen_1, arlen_1;
  logic [1:0]  bresp_1, rresp_1;

  int total = 0;
  int bad = 0;
  int w_done = 0;
  int ar_done = 0;
  int b_seen = 0;
  int r_bursts0 = 0;
  bit stall1 = 1'b0;
  bit tog_en = 1'b0;
  int tcnt = 0;

  b_exp_t exp_b[$];
  r_exp_t exp_r0[$];
  r_exp_t exp_r1[$];
  b_exp_t eb;
  r_exp_t er0;
  r_exp_t er1;

  axi_slv_rsp_model #(.READY_MODE(0), .LFSR_SEED(16'hACE1)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .in_awvalid(awvalid), .out_awready(awready), .in_awid(awid), .in_awaddr(awaddr), .in_awlen(awlen),
    .in_wvalid(wvalid), .out_wready(wready), .in_wlast(wlast),
    .out_bvalid(bvalid), .in_bready(bready), .out_bid(bid), .out_bresp(bresp),
    .in_arvalid(arvalid), .out_arready(arready), .in_arid(arid), .in_araddr(araddr), .in_arlen(arlen),
    .out_rvalid(rvalid), .in_rready(rready), .out_rid(rid), .out_rdata(rdata),
    .out_rresp(rresp), .out_rlast(rlast)
  );

  axi_slv_rsp_model #(.READY_MODE(1), .LFSR_SEED(16'hACE1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .in_awvalid(awvalid_1), .out_awready(awready_1), .in_awid(awid_1), .in_awaddr(awaddr_1),
    .in_awlen(awlen_1),
    .in_wvalid(wvalid_1), .out_wready(wready_1), .in_wlast(wlast_1),
    .out_bvalid(bvalid_1), .in_bready(bready_1), .out_bid(bid_1), .out_bresp(bresp_1),
    .in_arvalid(arvalid_1), .out_arready(arready_1), .in_arid(arid_1), .in_araddr(araddr_1),
    .in_arlen(arlen_1),
    .out_rvalid(rvalid_1), .in_rready(rready_1), .out_rid(rid_1), .out_rdata(rdata_1),
    .out_rresp(rresp_1), .out_rlast(rlast_1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event-missing-or-extra required=in-order-event", nm);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic b_exp_t mkb(input logic [3:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id;
    e.resp = resp;
    return e;
  endfunction

  function automatic r_exp_t mkr(input logic [3:0] id, input logic [31:0] data,
                                 input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id;
    e.data = data;
    e.resp = resp;
    e.last = last;
    return e;
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    n = 0;
    @(negedge aclk);
    while (!awready && n < 100) begin n++; @(negedge aclk); end
    if (!awready) fail_now("aw_handshake_timeout");
    step();
    awvalid = 1'b0;
  endtask

  task automatic w_send(input int nb, input int last_at);
    int n;
    for (int b = 1; b <= nb; b++) begin
      wvalid = 1'b1;
      wlast = (b == last_at);
      n = 0;
      @(negedge aclk);
      while (!wready && n < 100) begin n++; @(negedge aclk); end
      if (!wready) fail_now("w_handshake_timeout");
      step();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    w_done++;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
    n = 0;
    @(negedge aclk);
    while (!arready && n < 100) begin n++; @(negedge aclk); end
    if (!arready) fail_now("ar_handshake_timeout");
    step();
    arvalid = 1'b0;
    ar_done++;
  endtask

  task automatic ar1_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    arvalid_1 = 1'b1; arid_1 = id; araddr_1 = addr; arlen_1 = len;
    n = 0;
    @(negedge aclk);
    while (!arready_1 && n < 200) begin n++; @(negedge aclk); end
    if (!arready_1) fail_now("ar1_handshake_timeout");
    step();
    arvalid_1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r0.size() != 0) && n < 200) begin n++; step(); end
    if (exp_b.size() != 0 || exp_r0.size() != 0) fail_now("drain_timeout");
  endtask

  // B monitor for the unthrottled instance
  always @(negedge aclk) begin
    if (aresetn && bvalid && bready) begin
      b_seen++;
      chk("b_not_before_w_end", 64'(b_seen <= w_done), 64'd1);
      if (exp_b.size() == 0) fail_now("b_unexpected");
      else begin
        eb = exp_b.pop_front();
        chk("bid", 64'(bid), 64'(eb.id));
        chk("bresp", 64'(bresp), 64'(eb.resp));
      end
    end
  end

  // R monitor for the unthrottled instance
  always @(negedge aclk) begin
    if (aresetn && rvalid && rready) begin
      chk("r_not_before_ar", 64'((r_bursts0 + 1) <= ar_done), 64'd1);
      if (exp_r0.size() == 0) fail_now("r0_unexpected");
      else begin
        er0 = exp_r0.pop_front();
        chk("r0_rid", 64'(rid), 64'(er0.id));
        chk("r0_rdata", 64'(rdata), 64'(er0.data));
        chk("r0_rresp", 64'(rresp), 64'(er0.resp));
        chk("r0_rlast", 64'(rlast), 64'(er0.last));
      end
      if (rlast) r_bursts0++;
    end
  end

  // R monitor for the throttled instance: payload checked on every valid cycle, stalled or not
  always @(negedge aclk) begin
    if (!aresetn) stall1 = 1'b0;
    else begin
      if (stall1) chk("r1_valid_held", 64'(rvalid_1), 64'd1);
      if (rvalid_1) begin
        if (exp_r1.size() == 0) fail_now("r1_unexpected");
        else begin
          er1 = exp_r1[0];
          chk("r1_rid", 64'(rid_1), 64'(er1.id));
          chk("r1_rdata", 64'(rdata_1), 64'(er1.data));
          chk("r1_rresp", 64'(rresp_1), 64'(er1.resp));
          chk("r1_rlast", 64'(rlast_1), 64'(er1.last));
          if (rready_1) exp_r1.delete(0);
        end
      end
      stall1 = rvalid_1 && !rready_1;
    end
  end

  // Irregular rready pattern for the throttled instance
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (tog_en) begin
        tcnt++;
        rready_1 = (tcnt % 3 != 0);
      end
    end
  end

  initial begin
    int n;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; wvalid = 0; wlast = 0; bready = 1;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; rready = 1;
    awvalid_1 = 0; awid_1 = 0; awaddr_1 = 0; awlen_1 = 0; wvalid_1 = 0; wlast_1 = 0; bready_1 = 1;
    arvalid_1 = 0; arid_1 = 0; araddr_1 = 0; arlen_1 = 0; rready_1 = 0;

    // reset state
    repeat (2) @(negedge aclk);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst1_arready", 64'(arready_1), 64'd0);
    chk("rst1_awready", 64'(awready_1), 64'd0);
    step();
    aresetn = 1'b1;
    repeat (2) step();
    @(negedge aclk);
    chk("idle_awready", 64'(awready), 64'd1);
    chk("idle_arready", 64'(arready), 64'd1);
    chk("idle_wready_no_aw", 64'(wready), 64'd0);
    chk("idle1_wready_no_aw", 64'(wready_1), 64'd0);
    step();

    // single write burst
    exp_b.push_back(mkb(4'd3, 2'b00));
    aw_send(4'd3, 32'h100, 8'd3);
    w_send(4, 4);
    drain();

    // single read burst
    exp_r0.push_back(mkr(4'd5, 32'h40, 2'b00, 1'b0));
    exp_r0.push_back(mkr(4'd5, 32'h44, 2'b00, 1'b0));
    exp_r0.push_back(mkr(4'd5, 32'h48, 2'b00, 1'b1));
    ar_send(4'd5, 32'h40, 8'd2);
    drain();

    // AW FIFO full, then one completed burst frees a slot
    for (int i = 0; i < 4; i++) exp_b.push_back(mkb(4'(i), 2'b00));
    for (int i = 0; i < 4; i++) aw_send(4'(i), 32'h200 + 32'(i * 16), 8'd0);
    @(negedge aclk);
    chk("aw_full_awready", 64'(awready), 64'd0);
    step();
    w_send(1, 1);
    @(negedge aclk);
    chk("aw_freed_awready", 64'(awready), 64'd1);
    step();
    for (int i = 0; i < 3; i++) w_send(1, 1);
    drain();

    // early wlast, following burst counts from zero, missing wlast
    exp_b.push_back(mkb(4'd6, 2'b10));
    aw_send(4'd6, 32'h300, 8'd3);
    w_send(2, 2);
    exp_b.push_back(mkb(4'd7, 2'b00));
    aw_send(4'd7, 32'h304, 8'd1);
    w_send(2, 2);
    exp_b.push_back(mkb(4'd8, 2'b10));
    aw_send(4'd8, 32'h308, 8'd1);
    w_send(2, 0);
    drain();
    @(negedge aclk);
    chk("w_idle_after_bursts", 64'(wready), 64'd0);
    step();

    // B held under back-pressure
    bready = 1'b0;
    exp_b.push_back(mkb(4'd1, 2'b00));
    aw_send(4'd1, 32'h400, 8'd0);
    w_send(1, 1);
    repeat (3) step();
    @(negedge aclk);
    chk("b_hold_valid", 64'(bvalid), 64'd1);
    chk("b_hold_bid", 64'(bid), 64'd1);
    step();
    bready = 1'b1;
    drain();

    // out-of-range read and write
    exp_r0.push_back(mkr(4'd9, 32'h1000_0000, 2'b10, 1'b1));
    ar_send(4'd9, 32'h1000_0000, 8'd0);
    drain();
    exp_b.push_back(mkb(4'd10, 2'b10));
    aw_send(4'd10, 32'h1000_0000, 8'd0);
    w_send(1, 1);
    drain();

    // last in-range start address: burst crosses the limit but stays OKAY
    exp_r0.push_back(mkr(4'd11, 32'h0FFF_FFFC, 2'b00, 1'b0));
    exp_r0.push_back(mkr(4'd11, 32'h1000_0000, 2'b00, 1'b1));
    ar_send(4'd11, 32'h0FFF_FFFC, 8'd1);
    drain();

    // address wrap at ADDR_W
    exp_r0.push_back(mkr(4'd12, 32'hFFFF_FFFC, 2'b10, 1'b0));
    exp_r0.push_back(mkr(4'd12, 32'h0000_0000, 2'b10, 1'b1));
    ar_send(4'd12, 32'hFFFF_FFFC, 8'd1);
    drain();

    // throttled instance: three 8-beat bursts under irregular rready
    tog_en = 1'b1;
    for (int k = 1; k <= 3; k++)
      for (int b = 0; b < 8; b++)
        exp_r1.push_back(mkr(4'(k), 32'(k * 32'h1000 + b * 4), 2'b00, (b == 7)));
    ar1_send(4'd1, 32'h1000, 8'd7);
    ar1_send(4'd2, 32'h2000, 8'd7);
    ar1_send(4'd3, 32'h3000, 8'd7);
    n = 0;
    while (exp_r1.size() != 0 && n < 2000) begin n++; step(); end
    if (exp_r1.size() != 0) fail_now("r1_drain_timeout");

    // reset in the middle of a burst
    for (int b = 0; b < 8; b++)
      exp_r1.push_back(mkr(4'd4, 32'h4000 + 32'(b * 4), 2'b00, (b == 7)));
    ar1_send(4'd4, 32'h4000, 8'd7);
    n = 0;
    while (exp_r1.size() > 5 && n < 500) begin n++; step(); end
    if (exp_r1.size() > 5) fail_now("r1_midburst_timeout");
    aresetn = 1'b0;
    tog_en = 1'b0;
    rready_1 = 1'b0;
    exp_r1.delete();
    @(negedge aclk);
    chk("mid_rst_rvalid", 64'(rvalid_1), 64'd0);
    chk("mid_rst_rlast", 64'(rlast_1), 64'd0);
    chk("mid_rst_rdata", 64'(rdata_1), 64'd0);
    chk("mid_rst_rid", 64'(rid_1), 64'd0);
    chk("mid_rst_arready", 64'(arready_1), 64'd0);
    chk("mid_rst_bvalid", 64'(bvalid_1), 64'd0);
    chk("mid_rst_bid", 64'(bid_1), 64'd0);
    chk("mid_rst_bresp", 64'(bresp_1), 64'd0);
    chk("mid_rst_awready0", 64'(awready), 64'd0);
    step();
    aresetn = 1'b1;
    rready_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("post_rst_no_stale_r", 64'(rvalid_1), 64'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
